apb_ram_ws: RTL and testbench

- Parametrised APB slave word RAM. Successor to the fixed 4 KiB APB RAM on the peripheral bus.
- Adds generic data/address width and depth, per-byte write strobes (PSTRB), and a programmable number of wait states.
- Adds an error response for out-of-range or misaligned accesses.
- Sits behind the APB master/decoder alongside GPIO and the other peripherals.

---
 rtl/apb_ram_ws.sv | 133 +++++++++++++
 tb/tb_apb_ram_ws.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ram_ws.sv
// APB slave word RAM with byte strobes, programmable wait states and range checking.
// Define APB_RAM_SLVERR_EN to raise PSLVERR on out-of-range or misaligned accesses.
module apb_ram_ws #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic [ADDR_W-1:0]   PADDR,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [DATA_W-1:0]   PWDATA,
   input  logic [DATA_W/8-1:0] PSTRB,
   output logic [DATA_W-1:0]   PRDATA,
   output logic                PREADY,
   output logic                PSLVERR
);

   localparam int NB     = DATA_W / 8;
   localparam int LSB    = $clog2(NB);
   localparam int IDX_W  = ADDR_W - LSB;
   localparam int MEM_AW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NB-1:0]     strb_q;
   logic              do_capture, do_access;
   logic              out_of_range, bad;
   logic [MEM_AW-1:0] mem_addr;

   logic [DATA_W-1:0] mem [DEPTH];

   assign out_of_range = 32'(idx_q) >= 32'(DEPTH);
   assign mem_addr     = idx_q[MEM_AW-1:0];

`ifdef APB_RAM_SLVERR_EN
   logic mis_q;

   always_ff @(posedge PCLK) begin
      if (do_capture) mis_q <= (PADDR & ALIGN_MASK) != '0;
   end

   assign bad = out_of_range | mis_q;
`else
   // Low address bits select nothing: a misaligned access hits the containing word.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = |(PADDR & ALIGN_MASK);
   assign bad = out_of_range;
`endif

   // NOTE: every output of a combinational block gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      do_capture = 1'b0;
      do_access  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (PSEL && PENABLE) begin
               do_capture = 1'b1;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!PSEL) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               do_access = 1'b1;
               state_d   = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         PREADY  <= 1'b0;
         PRDATA  <= '0;
         PSLVERR <= 1'b0;
      end else begin
         state_q <= state_d;
         PREADY  <= do_access;
         if (do_capture) begin
            cnt_q <= 4'(WAIT_CYCLES);
         end else if (state_q == S_WAIT && PSEL && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
`ifdef APB_RAM_SLVERR_EN
         PSLVERR <= do_access && bad;
`else
         PSLVERR <= 1'b0;
`endif
         if (do_access && !write_q) begin
            PRDATA <= bad ? '0 : mem[mem_addr];
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (do_capture) begin
         idx_q   <= PADDR[ADDR_W-1:LSB];
         write_q <= PWRITE;
         wdata_q <= PWDATA;
         strb_q  <= PSTRB;
      end
   end

   // NOTE: the memory array has no reset; contents survive PRESET and only the
   // control path is cleared.
   always_ff @(posedge PCLK) begin
      if (!PRESET && do_access && write_q && !bad) begin
         for (int i = 0; i < NB; i++) begin
            if (strb_q[i]) mem[mem_addr][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_ram_ws.sv
// Scoreboard bench for apb_ram_ws: two instances (0 and 3 wait states, 1024 and 256 words)
// against a byte-addressed reference model.
module tb_apb_ram_ws;

   localparam int W_A = 0;
   localparam int W_B = 3;
   localparam int D_A = 1024;
   localparam int D_B = 256;

   logic        PCLK = 1'b0;
   logic        preset_a, preset_b, psel_a, psel_b, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata_a, prdata_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;

   always #5 PCLK = ~PCLK;

   apb_ram_ws #(.ADDR_W(12), .DATA_W(32), .DEPTH(D_A), .WAIT_CYCLES(W_A)) dut_a (
      .PCLK(PCLK), .PRESET(preset_a), .PADDR(paddr), .PSEL(psel_a), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));

   apb_ram_ws #(.ADDR_W(12), .DATA_W(32), .DEPTH(D_B), .WAIT_CYCLES(W_B)) dut_b (
      .PCLK(PCLK), .PRESET(preset_b), .PADDR(paddr), .PSEL(psel_b), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [7:0]  mbytes [2][4096];
   logic [31:0] last_rd [2];
   int          checks = 0;
   int          errors = 0;
   logic        prev_rdy_a = 1'b0;
   logic        prev_rdy_b = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wait_of(input int d);
      return (d == 0) ? W_A : W_B;
   endfunction

   function automatic int depth_of(input int d);
      return (d == 0) ? D_A : D_B;
   endfunction

   function automatic logic rdy(input int d);
      return (d == 0) ? pready_a : pready_b;
   endfunction

   task automatic set_psel(input int d, input logic v);
      if (d == 0) psel_a = v;
      else        psel_b = v;
   endtask

   // Byte-level reference: words are assembled from individually stored bytes.
   task automatic model(input int d, input logic wr, input logic [11:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, output exp_t e);
      int a, base;
      bit oor, mis, bad;
      a    = int'(addr);
      base = a - (a % 4);
      oor  = (a / 4) >= depth_of(d);
      mis  = (a % 4) != 0;
`ifdef APB_RAM_SLVERR_EN
      bad   = oor || mis;
      e.err = bad;
`else
      bad   = oor;
      e.err = 1'b0;
`endif
      if (wr) begin
         if (!bad)
            for (int i = 0; i < 4; i++)
               if (strb[i]) mbytes[d][base+i] = data[8*i +: 8];
      end else begin
         last_rd[d] = bad ? 32'h0 :
            {mbytes[d][base+3], mbytes[d][base+2], mbytes[d][base+1], mbytes[d][base]};
      end
      e.rdata = last_rd[d];
   endtask

   // Drives SETUP and ACCESS; returns just after the edge that samples the access cycle.
   task automatic start_xfer(input int d, input logic wr, input logic [11:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
      @(posedge PCLK); #1;
      paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
      set_psel(d, 1'b1); penable = 1'b0;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(posedge PCLK); #1;
   endtask

   task automatic xfer(input int d, input logic wr, input logic [11:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
      exp_t e;
      int   lat;
      model(d, wr, addr, data, strb, e);
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
      start_xfer(d, wr, addr, data, strb);
      // Bus payload changes after capture must not affect the access.
      paddr = 12'($urandom); pwdata = $urandom; pstrb = 4'($urandom); pwrite = 1'($urandom);
      lat = 0;
      while (lat < 40 && !rdy(d)) begin
         @(posedge PCLK); #1;
         lat++;
      end
      check((d == 0) ? "a_latency" : "b_latency", 32'(lat), 32'(1 + wait_of(d)));
      set_psel(d, 1'b0); penable = 1'b0;
   endtask

   always @(negedge PCLK) begin : mon_a
      exp_t e;
      if (pready_a) begin
         check("a_pready_pulse", 32'(prev_rdy_a), 32'h0);
         if (q_a.size() == 0) check("a_unexpected_pready", 32'(q_a.size()), 32'h1);
         else begin
            e = q_a.pop_front();
            check("a_prdata", prdata_a, e.rdata);
            check("a_pslverr", 32'(pslverr_a), 32'(e.err));
         end
      end
      prev_rdy_a = pready_a;
   end

   always @(negedge PCLK) begin : mon_b
      exp_t e;
      if (pready_b) begin
         check("b_pready_pulse", 32'(prev_rdy_b), 32'h0);
         if (q_b.size() == 0) check("b_unexpected_pready", 32'(q_b.size()), 32'h1);
         else begin
            e = q_b.pop_front();
            check("b_prdata", prdata_b, e.rdata);
            check("b_pslverr", 32'(pslverr_b), 32'(e.err));
         end
      end
      prev_rdy_b = pready_b;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [11:0] addr;
      preset_a = 1'b1; preset_b = 1'b1; psel_a = 1'b0; psel_b = 1'b0;
      penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      last_rd[0] = '0; last_rd[1] = '0;
      repeat (3) @(posedge PCLK);
      #1 preset_a = 1'b0; preset_b = 1'b0;
      repeat (3) begin
         @(negedge PCLK);
         check("rst_pready_a", 32'(pready_a), 32'h0);
         check("rst_prdata_a", prdata_a, 32'h0);
         check("rst_pslverr_a", 32'(pslverr_a), 32'h0);
         check("rst_pready_b", 32'(pready_b), 32'h0);
         check("rst_prdata_b", prdata_b, 32'h0);
         check("rst_pslverr_b", 32'(pslverr_b), 32'h0);
      end

      // Zero wait states: full write/read, byte strobes, empty strobe, misaligned hit.
      xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF);
      xfer(0, 0, 12'h010, 32'h0, 4'hF);
      xfer(0, 1, 12'h020, 32'h11223344, 4'hF);
      xfer(0, 1, 12'h020, 32'hAABBCCDD, 4'b0101);
      xfer(0, 0, 12'h020, 32'h0, 4'h0);
      xfer(0, 1, 12'h020, 32'hFFFFFFFF, 4'h0);
      xfer(0, 0, 12'h020, 32'h0, 4'hF);
      xfer(0, 1, 12'h012, 32'h0BADF00D, 4'hF);
      xfer(0, 0, 12'h010, 32'h0, 4'hF);

      // Three wait states, 256 words: out-of-range and misaligned accesses.
      xfer(1, 1, 12'h010, 32'h01020304, 4'hF);
      xfer(1, 0, 12'h010, 32'h0, 4'hF);
      xfer(1, 0, 12'h400, 32'h0, 4'hF);
      xfer(1, 1, 12'h012, 32'h99887766, 4'hF);
      xfer(1, 0, 12'h010, 32'h0, 4'hF);
      xfer(1, 1, 12'h000, 32'h13579BDF, 4'hF);
      xfer(1, 1, 12'h400, 32'hFEEDFACE, 4'hF);
      xfer(1, 0, 12'h000, 32'h0, 4'hF);

      // Reset in the middle of a waited write: nothing committed, no PREADY.
      xfer(1, 1, 12'h030, 32'hCAFEF00D, 4'hF);
      start_xfer(1, 1, 12'h030, 32'h12345678, 4'hF);
      check("rstabort_pready_a0", 32'(pready_b), 32'h0);
      @(posedge PCLK); #1;
      check("rstabort_pready_a1", 32'(pready_b), 32'h0);
      preset_b = 1'b1;
      @(posedge PCLK); #1;
      preset_b = 1'b0; set_psel(1, 1'b0); penable = 1'b0;
      last_rd[1] = '0;
      check("rstabort_prdata", prdata_b, 32'h0);
      repeat (6) begin
         @(posedge PCLK); #1;
         check("rstabort_pready", 32'(pready_b), 32'h0);
      end
      xfer(1, 0, 12'h030, 32'h0, 4'hF);

      // PSEL dropped while waiting: transfer abandoned.
      xfer(1, 1, 12'h034, 32'h5A5A5A5A, 4'hF);
      start_xfer(1, 1, 12'h034, 32'hBAD0BAD0, 4'hF);
      set_psel(1, 1'b0); penable = 1'b0;
      repeat (6) begin
         @(posedge PCLK); #1;
         check("pselabort_pready", 32'(pready_b), 32'h0);
      end
      xfer(1, 0, 12'h034, 32'h0, 4'hF);

      // Randomised traffic over an initialised 16-word window.
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 16; k++) xfer(d, 1, 12'(12'h100 + 4*k), $urandom, 4'hF);
         for (int n = 0; n < 60; n++) begin
            addr = 12'(12'h100 + 4*$urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) addr = 12'(addr + $urandom_range(1, 3));
            if (d == 1 && $urandom_range(0, 4) == 0) addr = 12'(12'h400 + $urandom_range(0, 12'hBFF));
            xfer(d, 1'($urandom), addr, $urandom, 4'($urandom));
         end
      end

      repeat (5) @(posedge PCLK);
      check("a_queue_empty", 32'(q_a.size()), 32'h0);
      check("b_queue_empty", 32'(q_b.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
